instruction_decode_stage: RTL and testbench
===========================================

# instruction_decode_stage

Pipelined RV32I decode stage; the producer of the execute-stage ALU control interface: immediate, immediate select, 4-bit ALU op and register addresses. Accepts fetched instruction words over a valid/ready handshake. Decodes OP, OP-IMM and LUI. Registers the decoded bundle toward execute through a skid buffer, so both handshake directions are registered. Sits between fetch and register-file read/ALU.

## Interface
- XLEN, 32, datapath width; only 32 supported.
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_if_instr  input  32  instruction word from fetch.
- i_if_valid  input  1  instruction word valid.
- o_if_ready  output  1  stage can accept; registered.
- i_flush  input  1  discard all held and in-flight instructions.
- o_id_valid  output  1  decoded bundle valid.
- i_ex_ready  input  1  execute accepts bundle.
- o_id_imm  output  XLEN  decoded immediate.
- o_imm_sel  output  1  1 = ALU B operand from o_id_imm, 0 = rs2 data.
- o_op_data  output  4  ALU operation code.
- o_rs1_addr, o_rs2_addr, o_rd_addr  output  5 each  register addresses.
- o_rd_we  output  1  destination write enable.
- o_illegal  output  1  instruction not decodable by this stage.

## Operation
- ALU op encoding: Add=0, Sub=1, Slt=2, Sltu=3, Xor=4, Or=5, And=6, Sll=7, Srl=8, Sra=9. 10-15 are never driven.
- OP (0110011): imm_sel=0, rd_we=1. funct3 000 with funct7 0x00 → Add; with 0x20 → Sub. 001 → Sll; 010 → Slt; 011 → Sltu; 100 → Xor. 101 with 0x00 → Srl; with 0x20 → Sra. 110 → Or; 111 → And. Any other funct7 → illegal.
- OP-IMM (0010011): imm_sel=1, rd_we=1, imm = sign-extended instr[31:20]. Mapping: 000 Add, 010 Slt, 011 Sltu, 100 Xor, 110 Or, 111 And.
- OP-IMM shifts: imm = zero-extended instr[24:20]. 001 needs funct7 0x00 → Sll. 101 with 0x00 → Srl; with 0x20 → Sra. Otherwise illegal.
- LUI (0110111): imm = {instr[31:12], 12'b0}, rs1_addr forced 0, op Add, imm_sel=1, rd_we=1.
- rs1/rs2/rd addresses are always taken from the instruction fields, except the LUI rs1 override.
- Illegal/unsupported opcode: bundle still passes with o_illegal=1, rd_we=0, op Add, imm 0, imm_sel 0.
- Flush: held bundles are dropped, i.e. the output register valid and the skid valid are both cleared. A word offered on the same edge is not accepted.

## Timing
- Reset: o_id_valid=0, all bundle outputs 0, skid empty, o_if_ready=1.
- Latency: 1 cycle. A word accepted on edge N is presented on o_id_valid after edge N.
- Throughput: 1/cycle while i_ex_ready=1.
- Handshakes: transfer when valid&&ready on a rising edge. o_id_valid and the bundle are held stable until accepted.
- Valid outputs never depend combinationally on ready inputs.
- Backpressure: output register full and i_ex_ready=0 → the next accepted word goes to the skid entry. o_if_ready = !skid_valid, so it drops the cycle after the skid fills.
- Skid drains to the output register on the first edge with i_ex_ready=1. o_if_ready returns the cycle after.
- Order is always preserved.
- Simultaneous accept-in and accept-out with the output register full: the new word replaces the output bundle and the skid stays empty.
- i_flush has priority over every handshake. After the flush edge: o_id_valid=0, o_if_ready=1.
- Reset asserted mid-operation: state clears immediately (asynchronous), with the same values as at reset.

## Structure
- Shared package riscv.svh holds:
  - opcode constants (OpcOp, OpcOpImm, OpcLui)
  - funct3/funct7 constants
  - the ALU op enum (AluAdd…AluSra), shared with the ALU
  - a packed decoded-bundle struct
- Sub-module decode_skid_buffer: a generic registered two-entry valid/ready pipeline register, parameterized on payload width, with flush.
- Decode logic is combinational in the top.

## Test plan
- 0xFFF10093 (addi x1,x2,-1) → imm 0xFFFFFFFF, op Add, imm_sel 1, rs1 2, rd 1, rd_we 1, o_illegal 0, one cycle later.
- 0x405201B3 (sub x3,x4,x5) → op Sub, imm_sel 0, rs1 4, rs2 5, rd 3. Also 0x4033D313 (srai x6,x7,3) → op Sra, imm 3, imm_sel 1.
- 0x123452B7 (lui x5,0x12345) → imm 0x12345000, rs1 0, op Add, imm_sel 1, rd 5. Also 0x0000007F → o_illegal 1, rd_we 0.
- Three back-to-back words with i_ex_ready=0 for 3 cycles → two captured, o_if_ready low after the second. The third is held by fetch. On release, all three exit in order, with no duplicates or drops.
- Fill output + skid, then pulse i_flush while i_if_valid=1 → next cycle o_id_valid 0, o_if_ready 1, nothing emitted. Then assert i_rst_n=0 mid-stream → outputs immediately at reset values.

Source files
------------

// File: rtl/instruction_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU op enum and the
// decoded bundle handed to execute.
package instruction_decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        alu_op_e         op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } id_bundle_t;

    localparam int BUNDLE_W = $bits(id_bundle_t);

    // funct3 -> op for the funct7=0x00 form; Sub/Sra are picked by the caller.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle of the decode stage.
interface instruction_decode_stage_if;
    import instruction_decode_stage_pkg::*;

    logic [31:0]     i_if_instr;
    logic            i_if_valid;
    logic            o_if_ready;
    logic            i_flush;
    logic            o_id_valid;
    logic            i_ex_ready;
    logic [XLEN-1:0] o_id_imm;
    logic            o_imm_sel;
    logic [3:0]      o_op_data;
    logic [4:0]      o_rs1_addr;
    logic [4:0]      o_rs2_addr;
    logic [4:0]      o_rd_addr;
    logic            o_rd_we;
    logic            o_illegal;

    modport master (
        input  i_if_instr, i_if_valid, i_flush, i_ex_ready,
        output o_if_ready, o_id_valid, o_id_imm, o_imm_sel, o_op_data,
               o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_we, o_illegal
    );

    modport slave (
        output i_if_instr, i_if_valid, i_flush, i_ex_ready,
        input  o_if_ready, o_id_valid, o_id_imm, o_imm_sel, o_op_data,
               o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_we, o_illegal
    );

endinterface

// File: rtl/instruction_decode_stage_skid.sv
// Two-entry registered valid/ready pipeline register (output reg + skid) with flush.
module decode_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             load_out;

    // in_ready comes straight from a flop, so upstream sees a registered ready.
    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && !skid_valid;
    assign load_out = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load_out) begin
            // Skid holds the older word, so it always wins the output slot.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) out_data <= in_data;
            end
        end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage for OP, OP-IMM and LUI; decoded bundle is registered
// toward execute through a skid buffer.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    instruction_decode_stage_if.master  bus
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    id_bundle_t  dec;
    id_bundle_t  held;

    assign instr  = bus.i_if_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        dec         = '0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.op      = ALU_ADD;
        legal       = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal     = 1'b1;
                dec.rd_we = 1'b1;
                case (f3)
                    F3_ADD_SUB: begin
                        if (f7 == F7_ALT)       dec.op = ALU_SUB;
                        else if (f7 != F7_BASE) legal  = 1'b0;
                    end
                    F3_SRL_SRA: begin
                        dec.op = ALU_SRL;
                        if (f7 == F7_ALT)       dec.op = ALU_SRA;
                        else if (f7 != F7_BASE) legal  = 1'b0;
                    end
                    default: begin
                        dec.op = alu_op_from_f3(f3);
                        legal  = (f7 == F7_BASE);
                    end
                endcase
            end
            OPC_OP_IMM: begin
                legal       = 1'b1;
                dec.rd_we   = 1'b1;
                dec.imm_sel = 1'b1;
                dec.op      = alu_op_from_f3(f3);
                dec.imm     = {{20{instr[31]}}, instr[31:20]};
                // Shifts reuse the upper immediate bits as funct7 and take a 5-bit shamt.
                if (f3 == F3_SLL) begin
                    dec.imm = {27'd0, instr[24:20]};
                    legal   = (f7 == F7_BASE);
                end else if (f3 == F3_SRL_SRA) begin
                    dec.imm = {27'd0, instr[24:20]};
                    if (f7 == F7_ALT)       dec.op = ALU_SRA;
                    else if (f7 != F7_BASE) legal  = 1'b0;
                end
            end
            OPC_LUI: begin
                legal       = 1'b1;
                dec.rd_we   = 1'b1;
                dec.imm_sel = 1'b1;
                dec.rs1     = 5'd0;
                dec.imm     = {instr[31:12], 12'd0};
            end
            default: ;
        endcase
        if (!legal) begin
            dec.imm     = '0;
            dec.imm_sel = 1'b0;
            dec.op      = ALU_ADD;
            dec.rd_we   = 1'b0;
        end
        dec.illegal = !legal;
    end

    decode_skid_buffer #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (bus.i_flush),
        .in_data   (dec),
        .in_valid  (bus.i_if_valid),
        .in_ready  (bus.o_if_ready),
        .out_data  (held),
        .out_valid (bus.o_id_valid),
        .out_ready (bus.i_ex_ready)
    );

    assign bus.o_id_imm   = held.imm;
    assign bus.o_imm_sel  = held.imm_sel;
    assign bus.o_op_data  = held.op;
    assign bus.o_rs1_addr = held.rs1;
    assign bus.o_rs2_addr = held.rs2;
    assign bus.o_rd_addr  = held.rd;
    assign bus.o_rd_we    = held.rd_we;
    assign bus.o_illegal  = held.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed and randomized checks of the decode stage against a queue-based
// model of held words and a rule-level RV32I decode reference.
module tb_instruction_decode_stage;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    instruction_decode_stage_if bus ();

    instruction_decode_stage dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] imm;
        logic        imm_sel;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we;
        logic        ill;
    } ref_t;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];
    logic [31:0] out_log[$];
    logic [3:0]  base_op [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        logic [6:0] f7 = w[31:25];
        logic [2:0] f3 = w[14:12];
        bit ok = 1'b0;
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
        r.imm = '0; r.imm_sel = 1'b0; r.op = 4'd0; r.rd_we = 1'b0;
        if (w[6:0] == 7'h33) begin
            if (f7 == 7'h00) begin ok = 1'b1; r.op = base_op[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; r.op = 4'd1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; r.op = 4'd9; end
        end else if (w[6:0] == 7'h13) begin
            r.imm_sel = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                r.imm = {27'd0, w[24:20]};
                ok    = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                r.op  = (f7 == 7'h20) ? 4'd9 : base_op[f3];
            end else begin
                r.imm = {{20{w[31]}}, w[31:20]};
                r.op  = base_op[f3];
                ok    = 1'b1;
            end
        end else if (w[6:0] == 7'h37) begin
            ok = 1'b1; r.imm = w & 32'hFFFFF000; r.rs1 = 5'd0; r.imm_sel = 1'b1;
        end
        if (ok) r.rd_we = 1'b1;
        else begin r.imm = '0; r.imm_sel = 1'b0; r.op = 4'd0; end
        r.ill = !ok;
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        int j = $urandom_range(0, 3);
        if (k < 4)       w[6:0] = 7'h33;
        else if (k < 7)  w[6:0] = 7'h13;
        else if (k == 7) w[6:0] = 7'h37;
        if (j == 0)      w[31:25] = 7'h00;
        else if (j == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic check_state(input string tag);
        ref_t r;
        chk({tag, "_valid"}, 64'(bus.o_id_valid), 64'(q.size() > 0));
        chk({tag, "_ready"}, 64'(bus.o_if_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            r = ref_decode(q[0]);
            chk({tag, "_imm"}, 64'(bus.o_id_imm), 64'(r.imm));
            chk({tag, "_ctrl"}, 64'({bus.o_imm_sel, bus.o_op_data, bus.o_rd_we, bus.o_illegal}),
                64'({r.imm_sel, r.op, r.rd_we, r.ill}));
            chk({tag, "_regs"}, 64'({bus.o_rs1_addr, bus.o_rs2_addr, bus.o_rd_addr}),
                64'({r.rs1, r.rs2, r.rd}));
        end
    endtask

    // Called just after a falling edge: drive, take one rising edge, update model, check.
    task automatic step(input logic [31:0] w, input logic v, input logic er, input logic fl);
        logic in_fire, out_fire;
        bus.i_if_instr = w;
        bus.i_if_valid = v;
        bus.i_ex_ready = er;
        bus.i_flush    = fl;
        in_fire  = v && bus.o_if_ready;
        out_fire = bus.o_id_valid && er;
        @(posedge i_clk);
        #1;
        if (fl) q.delete();
        else begin
            if (out_fire && q.size() > 0) out_log.push_back(q.pop_front());
            if (in_fire) q.push_back(w);
        end
        @(negedge i_clk);
        check_state("step");
    endtask

    initial begin
        bus.i_if_instr = '0; bus.i_if_valid = 1'b0; bus.i_ex_ready = 1'b0; bus.i_flush = 1'b0;
        #12;
        chk("rst_valid", 64'(bus.o_id_valid), 64'd0);
        chk("rst_ready", 64'(bus.o_if_ready), 64'd1);
        chk("rst_bundle", 64'({bus.o_id_imm, bus.o_imm_sel, bus.o_op_data, bus.o_rd_we, bus.o_illegal}), 64'd0);
        chk("rst_regs", 64'({bus.o_rs1_addr, bus.o_rs2_addr, bus.o_rd_addr}), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // directed decodes, one per cycle
        step(32'hFFF10093, 1'b1, 1'b1, 1'b0);
        chk("addi_imm", 64'(bus.o_id_imm), 64'hFFFFFFFF);
        chk("addi_ctrl", 64'({bus.o_op_data, bus.o_imm_sel, bus.o_rd_we, bus.o_illegal}), 64'({4'd0, 3'b110}));
        chk("addi_regs", 64'({bus.o_rs1_addr, bus.o_rd_addr}), 64'({5'd2, 5'd1}));
        step(32'h405201B3, 1'b1, 1'b1, 1'b0);
        chk("sub_ctrl", 64'({bus.o_op_data, bus.o_imm_sel}), 64'({4'd1, 1'b0}));
        chk("sub_regs", 64'({bus.o_rs1_addr, bus.o_rs2_addr, bus.o_rd_addr}), 64'({5'd4, 5'd5, 5'd3}));
        step(32'h4033D313, 1'b1, 1'b1, 1'b0);
        chk("srai", 64'({bus.o_op_data, bus.o_imm_sel, bus.o_id_imm}), 64'({4'd9, 1'b1, 32'd3}));
        step(32'h123452B7, 1'b1, 1'b1, 1'b0);
        chk("lui_imm", 64'(bus.o_id_imm), 64'h12345000);
        chk("lui_ctrl", 64'({bus.o_rs1_addr, bus.o_op_data, bus.o_imm_sel, bus.o_rd_addr}),
            64'({5'd0, 4'd0, 1'b1, 5'd5}));
        step(32'h0000007F, 1'b1, 1'b1, 1'b0);
        chk("illegal", 64'({bus.o_illegal, bus.o_rd_we}), 64'({1'b1, 1'b0}));
        step(32'h0, 1'b0, 1'b1, 1'b0);

        // backpressure: three words offered while execute stalls for three cycles
        out_log.delete();
        step(32'h00108093, 1'b1, 1'b0, 1'b0);
        step(32'h00210113, 1'b1, 1'b0, 1'b0);
        chk("bp_ready_low", 64'(bus.o_if_ready), 64'd0);
        step(32'h00318193, 1'b1, 1'b0, 1'b0);
        chk("bp_held_ready", 64'(bus.o_if_ready), 64'd0);
        step(32'h00318193, 1'b1, 1'b1, 1'b0);
        step(32'h00318193, 1'b1, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_count", 64'(out_log.size()), 64'd3);
        if (out_log.size() == 3) begin
            chk("bp_order0", 64'(out_log[0]), 64'h00108093);
            chk("bp_order1", 64'(out_log[1]), 64'h00210113);
            chk("bp_order2", 64'(out_log[2]), 64'h00318193);
        end

        // flush with both entries full and a word offered
        out_log.delete();
        step(32'h00500293, 1'b1, 1'b0, 1'b0);
        step(32'h00600313, 1'b1, 1'b0, 1'b0);
        step(32'h00700393, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", 64'(bus.o_id_valid), 64'd0);
        chk("flush_ready", 64'(bus.o_if_ready), 64'd1);
        step(32'h0, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush_nothing_out", 64'(out_log.size()), 64'd0);
        // flush racing an in/out transfer with only the output register full
        step(32'h00800413, 1'b1, 1'b0, 1'b0);
        step(32'h00900493, 1'b1, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(rand_word(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 24) == 0));

        // asynchronous reset in the middle of a stalled stream
        step(32'h00A00513, 1'b1, 1'b0, 1'b0);
        step(32'h00B00593, 1'b1, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.o_id_valid), 64'd0);
        chk("arst_ready", 64'(bus.o_if_ready), 64'd1);
        chk("arst_bundle", 64'({bus.o_id_imm, bus.o_imm_sel, bus.o_op_data, bus.o_rd_we, bus.o_illegal}), 64'd0);
        chk("arst_regs", 64'({bus.o_rs1_addr, bus.o_rs2_addr, bus.o_rd_addr}), 64'd0);
        q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 40; i++)
            step(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
